// File: rtl/fetch_issue_buffer.sv
// fetch_issue_buffer: fetches FETCH_WIDTH big-endian words per cycle from a
// byte-wide instruction memory into a circular buffer of BUF_DEPTH entries,
// and presents up to ISSUE_WIDTH oldest instructions (with PCs) to decode.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-low reset
//   instruction_memory  IMEM_BYTES bytes, word k = {m[a],m[a+1],m[a+2],m[a+3]}
//   branch_taken        flush buffer and redirect fetch to branch_target
//   branch_target       redirect byte address (bit 0 = MSB, low two bits dropped)
//   accept_count        slots decode consumed this cycle (in order from slot 0)
//   inst_out/inst_pc    slot i instruction and PC, zero when slot invalid
//   inst_valid          slot i valid (i < buf_count)
//   pc_output           next fetch PC
//   buf_count           occupied entries
//   fetch_stall         free entries < FETCH_WIDTH
//   accept_err          sticky: accept_count exceeded occupied entries
//
// Optional feature macro FETCH_PERF_EN: adds saturating 32-bit counters
// perf_fetch (push cycles), perf_stall (stall cycles), perf_flush (redirects).

module fib_issue_slot (
  input  logic        valid,
  input  logic [31:0] entry_inst,
  input  logic [31:0] entry_pc,
  output logic [31:0] inst,
  output logic [31:0] pc
);
  assign inst = valid ? entry_inst : '0;
  assign pc   = valid ? entry_pc   : '0;
endmodule

module fetch_issue_buffer #(
  parameter int FETCH_WIDTH = 2,
  parameter int ISSUE_WIDTH = 2,
  parameter int BUF_DEPTH   = 8,
  parameter int IMEM_BYTES  = 2048,
  localparam int CW   = $clog2(BUF_DEPTH + 1),
  localparam int AC_W = $clog2(ISSUE_WIDTH + 1)
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [IMEM_BYTES-1:0][7:0]        instruction_memory,
  input  logic                              branch_taken,
  input  logic [0:31]                       branch_target,
  input  logic [AC_W-1:0]                   accept_count,
  output logic [ISSUE_WIDTH-1:0][31:0]      inst_out,
  output logic [ISSUE_WIDTH-1:0][31:0]      inst_pc,
  output logic [ISSUE_WIDTH-1:0]            inst_valid,
  output logic [31:0]                       pc_output,
  output logic [CW-1:0]                     buf_count,
  output logic                              fetch_stall,
  output logic                              accept_err
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]                       perf_fetch,
  output logic [31:0]                       perf_stall,
  output logic [31:0]                       perf_flush
`endif
);
  localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int MW = $clog2(IMEM_BYTES);

  logic [AW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [31:0]   pc;
  logic          err;
  logic [31:0]   buf_inst [BUF_DEPTH];
  logic [31:0]   buf_pc   [BUF_DEPTH];

  logic          stall, push, over;
  int            pop_n;
  logic [FETCH_WIDTH-1:0][31:0] fetch_word;

  logic unused_tgt;
  assign unused_tgt = &{1'b0, branch_target[30:31]};

  // Depth need not be a power of two, so wrap explicitly.
  function automatic logic [AW-1:0] wrap(input logic [AW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    return AW'(s % BUF_DEPTH);
  endfunction

  // Free space is judged on the registered count, before this cycle's pops.
  always_comb begin
    stall = (BUF_DEPTH - int'(count)) < FETCH_WIDTH;
    push  = !branch_taken && !stall;
    over  = int'(accept_count) > int'(count);
    pop_n = over ? int'(count) : int'(accept_count);
  end

  for (genvar k = 0; k < FETCH_WIDTH; k++) begin : g_fetch
    logic [31:0]   addr;
    logic [MW-1:0] ai;
    assign addr = (pc + 32'(4 * k)) % 32'(IMEM_BYTES);
    assign ai   = MW'(addr);
    assign fetch_word[k] = {instruction_memory[ai],
                            instruction_memory[ai + MW'(1)],
                            instruction_memory[ai + MW'(2)],
                            instruction_memory[ai + MW'(3)]};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      pc    <= '0;
      err   <= 1'b0;
    end else if (branch_taken) begin
      // Redirect wins over any push/pop attempted this cycle.
      head  <= '0;
      tail  <= '0;
      count <= '0;
      pc    <= {branch_target[0:29], 2'b00};
    end else begin
      if (over) err <= 1'b1;
      head  <= wrap(head, pop_n);
      count <= CW'(int'(count) - pop_n + (push ? FETCH_WIDTH : 0));
      if (push) begin
        tail <= wrap(tail, FETCH_WIDTH);
        pc   <= pc + 32'(4 * FETCH_WIDTH);
      end
    end
  end

  // Storage is never read past count, so it needs no reset.
  always_ff @(posedge clock) begin
    if (push) begin
      for (int k = 0; k < FETCH_WIDTH; k++) begin
        buf_inst[wrap(tail, k)] <= fetch_word[k];
        buf_pc[wrap(tail, k)]   <= pc + 32'(4 * k);
      end
    end
  end

  for (genvar i = 0; i < ISSUE_WIDTH; i++) begin : g_slot
    logic [AW-1:0] rd_idx;
    assign rd_idx        = wrap(head, i);
    assign inst_valid[i] = int'(count) > i;
    fib_issue_slot u_slot (
      .valid      (inst_valid[i]),
      .entry_inst (buf_inst[rd_idx]),
      .entry_pc   (buf_pc[rd_idx]),
      .inst       (inst_out[i]),
      .pc         (inst_pc[i])
    );
  end

  assign pc_output   = pc;
  assign buf_count   = count;
  assign fetch_stall = stall;
  assign accept_err  = err;

`ifdef FETCH_PERF_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_fetch <= '0;
      perf_stall <= '0;
      perf_flush <= '0;
    end else begin
      if (push && !(&perf_fetch))         perf_fetch <= perf_fetch + 32'd1;
      if (stall && !(&perf_stall))        perf_stall <= perf_stall + 32'd1;
      if (branch_taken && !(&perf_flush)) perf_flush <= perf_flush + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_issue_buffer.sv
// Self-checking bench for fetch_issue_buffer: directed steps plus randomized
// traffic, compared each cycle against a queue-based reference model.
module tb_fetch_issue_buffer;
  localparam int FW = 2, IW = 2, D = 8, MB = 2048;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [MB-1:0][7:0]   mem;
  logic                 branch_taken;
  logic [31:0]          branch_target;
  logic [1:0]           accept_count;
  logic [IW-1:0][31:0]  inst_out, inst_pc;
  logic [IW-1:0]        inst_valid;
  logic [31:0]          pc_output;
  logic [3:0]           buf_count;
  logic                 fetch_stall, accept_err;

  always #5 clock = ~clock;

  fetch_issue_buffer dut (
    .clock(clock), .reset(reset), .instruction_memory(mem),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .accept_count(accept_count), .inst_out(inst_out), .inst_pc(inst_pc),
    .inst_valid(inst_valid), .pc_output(pc_output), .buf_count(buf_count),
    .fetch_stall(fetch_stall), .accept_err(accept_err)
  );

  int checks = 0, failures = 0;

  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  ent_t        q[$];
  logic [31:0] mpc;
  logic        merr;

  function automatic logic [31:0] wordval(int j);
    return 32'(j + 1) ^ (32'(j) << 20);
  endfunction

  function automatic logic [31:0] mem_word(logic [31:0] addr);
    return wordval(int'((addr % 32'(MB)) / 32'd4));
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    int n;
    n = q.size();
    for (int i = 0; i < IW; i++) begin
      chk("inst_valid", 32'(inst_valid[i]), 32'(i < n));
      chk("inst_out", inst_out[i], (i < n) ? q[i].inst : 32'd0);
      chk("inst_pc", inst_pc[i], (i < n) ? q[i].pc : 32'd0);
    end
    chk("pc_output", pc_output, mpc);
    chk("buf_count", 32'(buf_count), 32'(n));
    chk("fetch_stall", 32'(fetch_stall), 32'((D - n) < FW));
    chk("accept_err", 32'(accept_err), 32'(merr));
  endtask

  task automatic model_reset();
    q.delete();
    mpc  = 32'd0;
    merr = 1'b0;
  endtask

  task automatic model_clock(bit bt, logic [31:0] tgt, int acc);
    int   c;
    bit   psh;
    ent_t e;
    if (bt) begin
      q.delete();
      mpc = {tgt[31:2], 2'b00};
    end else begin
      c   = q.size();
      psh = (D - c) >= FW;
      if (acc > c) merr = 1'b1;
      for (int n = 0; n < ((acc < c) ? acc : c); n++) void'(q.pop_front());
      if (psh) begin
        for (int k = 0; k < FW; k++) begin
          e.pc   = mpc + 32'(4 * k);
          e.inst = mem_word(e.pc);
          q.push_back(e);
        end
        mpc = mpc + 32'(4 * FW);
      end
    end
  endtask

  // Called at a falling edge: drive, check current outputs, clock, update model.
  task automatic step(bit bt, logic [31:0] tgt, int acc);
    branch_taken  = bt;
    branch_target = tgt;
    accept_count  = 2'(acc);
    #1 check_model();
    @(posedge clock);
    model_clock(bt, tgt, acc);
    @(negedge clock);
  endtask

  task automatic rand_step(bit allow_err);
    bit          bt;
    logic [31:0] tgt;
    int          acc, lim;
    bt = ($urandom_range(0, 15) == 0);
    case ($urandom_range(0, 2))
      0:       tgt = 32'h7F0 + 32'($urandom_range(0, 15));
      1:       tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      default: tgt = $urandom;
    endcase
    lim = allow_err ? IW : ((q.size() < IW) ? q.size() : IW);
    acc = bt ? 0 : $urandom_range(0, lim);
    step(bt, tgt, acc);
  endtask

  initial begin
    logic [31:0] w;
    for (int j = 0; j < MB / 4; j++) begin
      w = wordval(j);
      mem[4*j]   = w[31:24];
      mem[4*j+1] = w[23:16];
      mem[4*j+2] = w[15:8];
      mem[4*j+3] = w[7:0];
    end
    reset = 1'b0;
    branch_taken = 1'b0;
    branch_target = 32'd0;
    accept_count = 2'd0;
    model_reset();
    #2 check_model();
    @(negedge clock);
    reset = 1'b1;

    // Fill with no consumption until stalled.
    step(0, 0, 0);
    #1 chk("t1_count", 32'(buf_count), 32'd2);
    chk("t1_pc", pc_output, 32'd8);
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    #1 chk("t1_stall", 32'(fetch_stall), 32'd1);
    chk("t1_pc_hold", pc_output, 32'd32);

    // Steady full-rate consumption, then alternating 1/2 (head wraps).
    for (int i = 0; i < 10; i++) step(0, 0, 2);
    for (int i = 0; i < 20; i++) step(0, 0, (i % 2) ? 2 : 1);

    // Redirect at count=6 to an unaligned target.
    step(1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    #1 chk("t4_count6", 32'(buf_count), 32'd6);
    step(1, 32'h107, 0);
    #1 chk("t4_valid", 32'(inst_valid), 32'd0);
    chk("t4_pc", pc_output, 32'h104);
    step(0, 0, 0);
    #1 chk("t4_slot0", inst_out[0], mem_word(32'h104));
    chk("t4_slot0_pc", inst_pc[0], 32'h104);

    // Memory index wrap at the top of instruction memory.
    step(1, 32'h7F8, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    #1 chk("t5_pc0", inst_pc[0], 32'h7F8);
    chk("t5_pc1", inst_pc[1], 32'h7FC);
    step(0, 0, 2);
    #1 chk("t5_wrap_inst", inst_out[0], 32'h0000_0001);
    chk("t5_wrap_pc", inst_pc[0], 32'h800);

    // Back-to-back redirects: last target wins.
    step(1, 32'h40, 0);
    step(1, 32'h1F3, 0);
    #1 chk("b2b_pc", pc_output, 32'h1F0);

    for (int i = 0; i < 300; i++) rand_step(0);

    // Over-accept on an empty buffer sets the sticky error.
    step(1, 32'h20, 0);
    step(0, 0, 2);
    #1 chk("t6_err", 32'(accept_err), 32'd1);
    step(0, 0, 0);
    step(0, 0, 1);
    #1 chk("t6_err_sticky", 32'(accept_err), 32'd1);

    for (int i = 0; i < 200; i++) rand_step(1);

    // Asynchronous reset mid-cycle clears state immediately.
    step(0, 0, 0);
    #2 reset = 1'b0;
    #1 chk("ar_count", 32'(buf_count), 32'd0);
    chk("ar_pc", pc_output, 32'd0);
    chk("ar_err", 32'(accept_err), 32'd0);
    chk("ar_valid", 32'(inst_valid), 32'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) rand_step(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
